// File: rtl/mmc_cmd_deserialiser.sv
// MMC/SD CMD-line response deserialiser: start-bit hunt with timeout, 48/136-bit capture, end-bit check.
// Optional CRC7 checking of the received frame is enabled by defining MMC_CMD_CRC_CHECK_EN.
module mmc_cmd_deserialiser (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         bitclk_i,
  input  logic         start_i,
  input  logic         abort_i,
  input  logic         r2_mode_i,
  input  logic         cmd_i,
  output logic [135:0] resp_o,
  output logic         active_o,
  output logic         complete_o,
  output logic         timeout_o,
  output logic         crc_err_o
);

  typedef enum logic [1:0] {IDLE, WAIT_START, RECEIVE, END} state_t;

  state_t      state_q;
  logic        clk_q;
  logic        r2_q;
  logic [7:0]  bit_cnt;
  logic [6:0]  to_cnt;
  logic [7:0]  cnt_next_w;
  logic        sample_w;
  logic        last_bit_w;
  logic        crc_bad_w;

  assign sample_w   = bitclk_i & ~clk_q;
  assign cnt_next_w = bit_cnt + 8'd1;
  assign last_bit_w = (cnt_next_w == (r2_q ? 8'd136 : 8'd48));

`ifdef MMC_CMD_CRC_CHECK_EN
  logic [6:0] crc_q;
  logic       crc_take_w;
  logic       crc_fb_w;

  // CRC covers frame bits [47:8] (counts 1..40) or, in R2, bits [127:8] (counts 9..128).
  always_comb begin
    crc_take_w = 1'b0;
    if (state_q == WAIT_START)
      crc_take_w = ~cmd_i & ~r2_q;
    else if (state_q == RECEIVE)
      crc_take_w = r2_q ? (cnt_next_w >= 8'd9 && cnt_next_w <= 8'd128)
                        : (cnt_next_w <= 8'd40);
  end

  assign crc_fb_w  = crc_q[6] ^ cmd_i;
  // At the final sample resp_o[6:0] already holds frame bits [7:1].
  assign crc_bad_w = (crc_q != resp_o[6:0]);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      crc_q <= '0;
    else if (abort_i || state_q == IDLE)
      crc_q <= '0;
    else if (sample_w && crc_take_w)
      crc_q <= {crc_q[5:3], crc_q[2] ^ crc_fb_w, crc_q[1:0], crc_fb_w};
  end
`else
  assign crc_bad_w = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      clk_q      <= 1'b0;
      r2_q       <= 1'b0;
      bit_cnt    <= '0;
      to_cnt     <= '0;
      resp_o     <= '0;
      active_o   <= 1'b0;
      complete_o <= 1'b0;
      timeout_o  <= 1'b0;
      crc_err_o  <= 1'b0;
    end else begin
      clk_q      <= bitclk_i;
      complete_o <= 1'b0;
      timeout_o  <= 1'b0;
      if (abort_i) begin
        state_q  <= IDLE;
        active_o <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start_i) begin
              state_q   <= WAIT_START;
              active_o  <= 1'b1;
              resp_o    <= '0;
              bit_cnt   <= '0;
              to_cnt    <= '0;
              crc_err_o <= 1'b0;
              r2_q      <= r2_mode_i;
            end
          end
          WAIT_START: begin
            if (sample_w) begin
              if (!cmd_i) begin
                resp_o  <= {resp_o[134:0], 1'b0};
                bit_cnt <= 8'd1;
                state_q <= RECEIVE;
              end else begin
                to_cnt <= to_cnt + 7'd1;
                if (to_cnt == 7'd63) begin
                  timeout_o <= 1'b1;
                  active_o  <= 1'b0;
                  state_q   <= IDLE;
                end
              end
            end
          end
          RECEIVE: begin
            if (sample_w) begin
              resp_o  <= {resp_o[134:0], cmd_i};
              bit_cnt <= cnt_next_w;
              if (last_bit_w) begin
                state_q    <= END;
                complete_o <= 1'b1;
                crc_err_o  <= ~cmd_i | crc_bad_w;
              end
            end
          end
          END: begin
            state_q  <= IDLE;
            active_o <= 1'b0;
          end
          default: begin
            state_q  <= IDLE;
            active_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/mmc_cmd_deserialiser.md
MMC_CMD_DESERIALISER -- requirements
Module: mmc_cmd_deserialiser

Interface
REQ-001 SHALL have port clk_i, input, 1: single system clock; all state on its rising edge.
REQ-002 SHALL have port rst_i, input, 1: reset, asynchronous, active-high.
REQ-003 SHALL have port bitclk_i, input, 1: card bit clock, level sampled in the clk_i domain.
REQ-004 SHALL have port start_i, input, 1: one-cycle pulse that arms response capture.
REQ-005 SHALL have port abort_i, input, 1: forces return to IDLE.
REQ-006 SHALL have port r2_mode_i, input, 1: 1 = 136-bit response, 0 = 48-bit; sampled on start_i.
REQ-007 SHALL have port cmd_i, input, 1: CMD line from the card.
REQ-008 SHALL have port resp_o, output, 136: received frame, right-aligned (last bit received in bit 0).
REQ-009 SHALL have port active_o, output, 1: high whenever state is not IDLE.
REQ-010 SHALL have port complete_o, output, 1: one-cycle pulse when a full frame has been received.
REQ-011 SHALL have port timeout_o, output, 1: one-cycle pulse when no start bit arrives in time.
REQ-012 SHALL have port crc_err_o, output, 1: frame error flag, valid from complete_o until the next start_i.

Function
REQ-013 SHALL register bitclk_i into clk_q; sample strobe sample_w = bitclk_i & ~clk_q (rising edge); cmd_i is captured only on sample_w.
REQ-014 SHALL implement states IDLE, WAIT_START, RECEIVE, END.
REQ-015 IDLE->WAIT_START on start_i; same cycle clears resp_o, bit counter, timeout counter and crc_err_o, and latches r2_mode_i.
REQ-016 WAIT_START: each sample_w with cmd_i=1 increments a 7-bit timeout counter; on the 64th such sample, pulse timeout_o and go to IDLE.
REQ-017 WAIT_START: sample_w with cmd_i=0 (start bit) shifts the 0 into resp_o, sets bit count to 1 and goes to RECEIVE; a start bit on the 64th sample is accepted, with no timeout.
REQ-018 RECEIVE: each sample_w performs resp_q <= {resp_q[134:0], cmd_i} and increments the bit count; the sample making the count 48 (or 136 in R2 mode) goes to END.
REQ-019 END SHALL last exactly one clk_i cycle: pulse complete_o, then go to IDLE.
REQ-020 In 48-bit mode resp_o[135:48] SHALL read 0.
REQ-021 SHALL set crc_err_o if the final (end) bit received is 0.
REQ-022 abort_i SHALL have the highest priority: next state is IDLE and no complete_o or timeout_o pulse occurs; resp_o is left as is.
REQ-023 start_i SHALL be ignored outside IDLE; start_i and abort_i together give IDLE.
REQ-024 When start_i and sample_w coincide in IDLE, that sample SHALL NOT be used as a response bit.

Reset
REQ-025 Reset SHALL give state IDLE, clk_q=0, resp_o=0, all counters 0, and all of active_o, complete_o, timeout_o and crc_err_o at 0.
REQ-026 Reset asserted mid-frame SHALL discard the frame with no pulse on any output.

Configuration
REQ-027 With MMC_CMD_CRC_CHECK_EN defined, the block SHALL compute CRC7 (x^7+x^3+1, cleared in IDLE):
- 48-bit mode: over received frame bits [47:8].
- R2 mode: over bits [127:8].
- crc_err_o SHALL also be set when the computed CRC differs from frame bits [7:1].
REQ-028 Without MMC_CMD_CRC_CHECK_EN, no CRC logic SHALL exist and crc_err_o SHALL reflect only the end-bit check (REQ-021).
REQ-029 Software SHALL ignore crc_err_o CRC results for R3 (no valid CRC); the hardware does not distinguish R3.

Verification
REQ-030 Scenario, CRC define on, 48-bit mode: start_i, 5 idle-high bits, then frame 0x48000001AA87 -> complete_o pulse, resp_o=0x48000001AA87, crc_err_o=0.
REQ-031 Scenario: frame 0x400000000097 -> complete_o pulse, crc_err_o=1 with CRC define on, 0 with it off.
REQ-032 Scenario: start_i, cmd_i held high for 64 bitclk edges -> timeout_o pulse on the 64th sample, no complete_o, active_o drops next cycle.
REQ-033 Scenario: r2_mode_i=1, 136-bit frame with valid CRC over [127:8] and end bit 1 -> complete_o after the 136th sample, crc_err_o=0.
REQ-034 Scenario: abort_i after 20 received bits -> IDLE next cycle, no complete_o, and a new start_i then captures a clean frame correctly.
REQ-035 Scenario: frame 0x48000001AA86 (end bit 0) -> crc_err_o=1 in both configurations.
